piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 7 +
 rtl/piso_serializer_bit_counter.sv | 20 ++
 rtl/piso_serializer.sv | 54 +++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter-width helper for the serializer.
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: saturating 0..MAX counter with synchronous clear.
module bit_counter
  import piso_pkg::*;
#(
  parameter int MAX = 7,
  localparam int W = cnt_w(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);
  assign at_max = count == W'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && !at_max) count <= count + 1'b1;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel word in, one bit per en tick out.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);
  piso_state_t state;
  logic [WIDTH-1:0] shreg;
  logic [cnt_w(WIDTH)-1:0] cnt;
  logic at_max, shifting, last, accept;
  if (WIDTH < 2) begin : g_width_chk
    $error("piso_serializer: WIDTH must be at least 2");
  end
  assign shifting = state == SHIFT && en;
  assign last = shifting && at_max;
  assign in_ready = state == IDLE || last;
  assign accept = in_valid && in_ready;
  bit_counter #(.MAX(WIDTH - 1)) u_cnt (
    .clk,
    .rst_n,
    .clear(accept || last),
    .inc(shifting),
    .count(cnt),
    .at_max
  );
  // accept wins over last so a waiting word follows with no idle bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= in_data;
    end else if (last) state <= IDLE;
    else if (shifting) shreg <= LSB_FIRST ? shreg >> 1 : shreg << 1;
  assign sdo_valid = state == SHIFT;
  assign busy = sdo_valid;
  assign sof = sdo_valid && cnt == '0;
  assign eof = sdo_valid && at_max;
  assign sdo = sdo_valid && (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench, lane 0 MSB-first and lane 1 LSB-first.
module tb_piso_serializer;
  typedef struct packed {
    logic lane;
    logic b;
    logic sf;
    logic ef;
  } exp_t;
  typedef logic [7:0] tbl_t[10];
  logic clk, rst_n, en;
  logic [7:0] in_data;
  logic [1:0] iv, rdy, sdo, sv, sof, eof, busy;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[0]), .in_ready(rdy[0]),
    .en(en), .sdo(sdo[0]), .sdo_valid(sv[0]), .sof(sof[0]), .eof(eof[0]), .busy(busy[0])
  );
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[1]), .in_ready(rdy[1]),
    .en(en), .sdo(sdo[1]), .sdo_valid(sv[1]), .sof(sof[1]), .eof(eof[1]), .busy(busy[1])
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_word(input logic lane, input logic [7:0] w);
    for (int i = 0; i < 8; i++)
      q.push_back('{lane: lane, b: lane ? w[i] : w[7-i], sf: i == 0, ef: i == 7});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Drives en every k cycles from the accept edge, feeds in_data from tbl, drops in_valid after edge `drop`.
  task automatic run(input int lane, input int k, input int n_exp, input int drop, input tbl_t tbl,
                     input string nm);
    int n = 0;
    for (int c = 0; c < 200; c++) begin
      cyc();
      en = ((c + 1) % k) == 0;
      in_data = tbl[(c + 1 > 9) ? 9 : c + 1];
      if (c >= drop) iv = '0;
      @(negedge clk);
      if (sv[lane]) n++;
      else if (n > 0) break;
    end
    chk(nm, n, n_exp);
  endtask
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else
      for (int l = 0; l < 2; l++) begin
        if (sv[l]) begin
          chk("busy", busy[l], 1);
          if (q.size() == 0 || q[0].lane != l[0]) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_bit lane %0d: sdo_valid=1, no bit expected at %0t", l, $time);
          end else begin
            chk($sformatf("sdo%0d", l), sdo[l], q[0].b);
            chk($sformatf("sof%0d", l), sof[l], q[0].sf);
            chk($sformatf("eof%0d", l), eof[l], q[0].ef);
            chk($sformatf("in_ready_busy%0d", l), rdy[l], en && q[0].ef);
            if (en) void'(q.pop_front());
          end
        end else begin
          chk($sformatf("idle_outputs%0d", l), {sdo[l], sof[l], eof[l], busy[l]}, 0);
          chk($sformatf("in_ready_idle%0d", l), rdy[l], 1);
        end
      end
  end
  initial begin
    tbl_t t;
    rst_n = 0;
    iv = '0;
    en = 0;
    in_data = '0;
    repeat (3) cyc();
    chk("reset_sdo_valid", sv, 0);
    chk("reset_flags", {sdo, sof, eof, busy}, 0);
    rst_n = 1;
    cyc();
    // single word MSB-first
    in_data = 8'hA5;
    iv = 2'b01;
    en = 1;
    push_word(0, 8'hA5);
    t = '{default: 8'hA5};
    run(0, 1, 8, 0, t, "single_len");
    // reset mid-word after three bits
    in_data = 8'hA5;
    iv = 2'b01;
    en = 1;
    push_word(0, 8'hA5);
    repeat (4) cyc();
    iv = '0;
    #2 rst_n = 0;
    #1;
    chk("midrst_sdo_valid", sv[0], 0);
    chk("midrst_flags", {sdo[0], sof[0], eof[0], busy[0]}, 0);
    @(negedge clk);
    cyc();
    rst_n = 1;
    #1 chk("midrst_in_ready", rdy[0], 1);
    cyc();
    // back-to-back LSB-first
    in_data = 8'h3C;
    iv = 2'b10;
    en = 1;
    push_word(1, 8'h3C);
    push_word(1, 8'hC3);
    t = '{default: 8'hC3};
    run(1, 1, 16, 8, t, "b2b_len");
    cyc();
    // throttled en, one tick in three
    in_data = 8'h81;
    iv = 2'b01;
    en = 0;
    push_word(0, 8'h81);
    t = '{default: 8'h00};
    run(0, 3, 24, 0, t, "throttle_len");
    cyc();
    // in_data churn while in_valid held: only the value at eof&&en loads
    t = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 8'h00, 8'h5A, 8'h3C, 8'hE7, 8'h99};
    in_data = t[0];
    iv = 2'b01;
    en = 1;
    push_word(0, 8'h11);
    push_word(0, 8'hE7);
    run(0, 1, 16, 8, t, "bp_len");
    cyc();
    // accept in IDLE with en low, bit held until en
    in_data = 8'h96;
    iv = 2'b01;
    en = 0;
    push_word(0, 8'h96);
    cyc();
    iv = '0;
    in_data = 8'h00;
    @(negedge clk);
    chk("idle_accept_valid", sv[0], 1);
    chk("idle_accept_sof", sof[0], 1);
    repeat (3) cyc();
    t = '{default: 8'h00};
    run(0, 1, 8, 0, t, "hold_len");
    repeat (2) cyc();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
